// File: rtl/cond_branch_eval_if.sv
// ============================================================================
// Module      : cond_branch_eval_if
// Description : Flag-write, branch-request and redirect signals for cond_branch_eval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cond_branch_eval_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              flag_we;
    logic              n_in;
    logic              z_in;
    logic              c_in;
    logic              v_in;
    logic              br_valid;
    logic              br_ready;
    logic [3:0]        br_cond;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_offset;
    logic              redirect_valid;
    logic              redirect_ready;
    logic [ADDR_W-1:0] redirect_pc;
    logic [3:0]        flags_q;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output flag_we, n_in, z_in, c_in, v_in,
        output br_valid, br_cond, br_pc, br_offset, redirect_ready,
        input  br_ready, redirect_valid, redirect_pc, flags_q, taken_cnt
    );

    modport slave (
        input  flag_we, n_in, z_in, c_in, v_in,
        input  br_valid, br_cond, br_pc, br_offset, redirect_ready,
        output br_ready, redirect_valid, redirect_pc, flags_q, taken_cnt
    );
endinterface

`default_nettype wire

// File: rtl/cond_branch_eval.sv
// ============================================================================
// Module      : cond_branch_eval
// Description : NZCV flag register, condition evaluation and taken-branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_branch_eval #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    cond_branch_eval_if.slave bus
);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_EVAL     = 2'd1;
    localparam logic [1:0] c_REDIRECT = 2'd2;

    logic [1:0]        r_state;
    logic [3:0]        r_flags;
    logic [3:0]        r_cap_flags;
    logic [3:0]        r_cond;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_off;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic              r_redirect_valid;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic [3:0]        w_flags_in;
    logic [3:0]        w_flags_eff;
    logic              w_accept;
    logic              w_taken;
    logic              w_n, w_z, w_c, w_v;
    logic [ADDR_W-1:0] w_target;

    assign w_flags_in  = {bus.n_in, bus.z_in, bus.c_in, bus.v_in};
    assign bus.br_ready = (r_state == c_IDLE) && !reset;
    assign w_accept    = bus.br_valid && bus.br_ready;
    // A flag write in the accept cycle is bypassed straight into the branch.
    assign w_flags_eff = bus.flag_we ? w_flags_in : r_flags;
    assign w_target    = r_pc + (r_off << 2);

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flags_q        = r_flags;
    assign bus.taken_cnt      = r_taken_cnt;

    always_comb begin
        {w_n, w_z, w_c, w_v} = r_cap_flags;
        w_taken = 1'b0;
        case (r_cond)
            4'd0:    w_taken = w_z;
            4'd1:    w_taken = !w_z;
            4'd2:    w_taken = !w_c;
            4'd3:    w_taken = w_c;
            4'd4:    w_taken = w_n;
            4'd5:    w_taken = !w_n;
            4'd6:    w_taken = w_v;
            4'd7:    w_taken = !w_v;
            4'd8:    w_taken = !w_c && !w_z;
            4'd9:    w_taken = w_c || w_z;
            4'd10:   w_taken = (w_n == w_v);
            4'd11:   w_taken = (w_n != w_v);
            4'd12:   w_taken = !w_z && (w_n == w_v);
            4'd13:   w_taken = w_z || (w_n != w_v);
            4'd14:   w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_IDLE;
            r_flags          <= 4'd0;
            r_cap_flags      <= 4'd0;
            r_cond           <= 4'd0;
            r_pc             <= '0;
            r_off            <= '0;
            r_redirect_pc    <= '0;
            r_redirect_valid <= 1'b0;
            r_taken_cnt      <= '0;
        end else begin
            if (bus.flag_we) begin
                r_flags <= w_flags_in;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_cond      <= bus.br_cond;
                        r_pc        <= bus.br_pc;
                        r_off       <= bus.br_offset;
                        r_cap_flags <= w_flags_eff;
                        r_state     <= c_EVAL;
                    end
                end
                c_EVAL: begin
                    r_redirect_pc    <= w_target;
                    r_redirect_valid <= w_taken;
                    r_state          <= w_taken ? c_REDIRECT : c_IDLE;
                end
                c_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_taken_cnt      <= r_taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_state          <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cond_branch_eval.sv
// ============================================================================
// Module      : tb_cond_branch_eval
// Description : Directed self-checking bench for cond_branch_eval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_branch_eval;
    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    logic [15:0] exp_cnt;

    cond_branch_eval_if #(.ADDR_W(32), .CNT_W(16)) bus ();
    cond_branch_eval_if #(.ADDR_W(32), .CNT_W(3))  bus_s ();

    cond_branch_eval #(.ADDR_W(32), .CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Narrow-counter twin sees identical traffic so counter wrap is reachable quickly.
    cond_branch_eval #(.ADDR_W(32), .CNT_W(3)) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    assign bus_s.flag_we        = bus.flag_we;
    assign bus_s.n_in           = bus.n_in;
    assign bus_s.z_in           = bus.z_in;
    assign bus_s.c_in           = bus.c_in;
    assign bus_s.v_in           = bus.v_in;
    assign bus_s.br_valid       = bus.br_valid;
    assign bus_s.br_cond        = bus.br_cond;
    assign bus_s.br_pc          = bus.br_pc;
    assign bus_s.br_offset      = bus.br_offset;
    assign bus_s.redirect_ready = bus.redirect_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, b;
        {n, z, c, v} = f;
        b = 1'b0;
        case (code[3:1])
            3'd0: b = z;
            3'd1: b = !c;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = !c && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        if (code == 4'd15) return 1'b0;
        return code[0] ? !b : b;
    endfunction

    task automatic write_flags(input logic [3:0] nzcv);
        bus.flag_we = 1'b1;
        {bus.n_in, bus.z_in, bus.c_in, bus.v_in} = nzcv;
        step;
        bus.flag_we = 1'b0;
        check("flags_q_write", bus.flags_q, nzcv);
    endtask

    // Issues one branch with redirect_ready held high and checks the cycle-exact response.
    task automatic do_branch(input logic [3:0] code, input logic [31:0] pc, input logic [31:0] off,
                             input logic we, input logic [3:0] nzcv,
                             input logic exp_taken, input logic [31:0] exp_pc);
        check("br_ready_idle", bus.br_ready, 1'b1);
        bus.br_valid       = 1'b1;
        bus.br_cond        = code;
        bus.br_pc          = pc;
        bus.br_offset      = off;
        bus.redirect_ready = 1'b1;
        bus.flag_we        = we;
        if (we) {bus.n_in, bus.z_in, bus.c_in, bus.v_in} = nzcv;
        step;
        bus.br_valid = 1'b0;
        bus.flag_we  = 1'b0;
        check("eval_valid", bus.redirect_valid, 1'b0);
        check("eval_ready", bus.br_ready, 1'b0);
        step;
        check("taken", bus.redirect_valid, exp_taken);
        if (exp_taken) begin
            check("redirect_pc", bus.redirect_pc, exp_pc);
            exp_cnt = exp_cnt + 16'd1;
            step;
        end
        check("ready_after", bus.br_ready, 1'b1);
        check("taken_cnt", bus.taken_cnt, exp_cnt);
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] off;
        n_total = 0;
        n_bad   = 0;
        exp_cnt = 16'd0;
        reset = 1'b1;
        bus.flag_we = 1'b0;
        {bus.n_in, bus.z_in, bus.c_in, bus.v_in} = 4'b0000;
        bus.br_valid = 1'b0;
        bus.br_cond = 4'd0;
        bus.br_pc = 32'd0;
        bus.br_offset = 32'd0;
        bus.redirect_ready = 1'b1;
        step; step; step;

        check("rst_flags", bus.flags_q, 4'd0);
        check("rst_rvalid", bus.redirect_valid, 1'b0);
        check("rst_rpc", bus.redirect_pc, 32'd0);
        check("rst_cnt", bus.taken_cnt, 16'd0);
        check("rst_br_ready", bus.br_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", bus.br_ready, 1'b1);

        // Basic taken EQ
        write_flags(4'b0100);
        do_branch(4'd0, 32'h100, 32'd4, 1'b0, 4'd0, 1'b1, 32'h110);
        check("cnt_one", bus.taken_cnt, 16'd1);

        // Bypass: Z cleared in the accept cycle makes EQ not taken
        do_branch(4'd0, 32'h100, 32'd4, 1'b1, 4'b0000, 1'b0, 32'h0);
        check("bypass_flags_q", bus.flags_q, 4'b0000);

        // Full sweep of codes against every flag combination
        for (int f = 0; f < 16; f++) begin
            write_flags(f[3:0]);
            for (int c = 0; c < 16; c++) begin
                pc  = $urandom;
                off = $urandom;
                do_branch(c[3:0], pc, off, 1'b0, 4'd0, model(c[3:0], f[3:0]), pc + (off << 2));
            end
        end

        // Address wrap in both directions
        do_branch(4'd14, 32'hFFFF_FFF8, 32'd4, 1'b0, 4'd0, 1'b1, 32'h0000_0008);
        do_branch(4'd14, 32'h100, 32'hFFFF_FFFF, 1'b0, 4'd0, 1'b1, 32'h0000_00FC);

        // Backpressure with a flag write during the stall
        write_flags(4'b0000);
        bus.br_valid = 1'b1;
        bus.br_cond = 4'd14;
        bus.br_pc = 32'h2000;
        bus.br_offset = 32'h10;
        bus.redirect_ready = 1'b0;
        step;
        bus.br_valid = 1'b0;
        step;
        check("bp_valid", bus.redirect_valid, 1'b1);
        check("bp_pc", bus.redirect_pc, 32'h2040);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.flag_we = 1'b1;
                {bus.n_in, bus.z_in, bus.c_in, bus.v_in} = 4'b1010;
            end
            step;
            bus.flag_we = 1'b0;
            check("bp_hold_valid", bus.redirect_valid, 1'b1);
            check("bp_hold_pc", bus.redirect_pc, 32'h2040);
            check("bp_br_ready", bus.br_ready, 1'b0);
        end
        check("bp_flags_q", bus.flags_q, 4'b1010);
        check("bp_cnt_hold", bus.taken_cnt, exp_cnt);
        bus.redirect_ready = 1'b1;
        step;
        exp_cnt = exp_cnt + 16'd1;
        check("bp_release_ready", bus.br_ready, 1'b1);
        check("bp_release_valid", bus.redirect_valid, 1'b0);
        check("bp_release_cnt", bus.taken_cnt, exp_cnt);

        // Reset while a redirect is pending
        bus.br_valid = 1'b1;
        bus.br_cond = 4'd14;
        bus.br_pc = 32'h300;
        bus.br_offset = 32'd1;
        bus.redirect_ready = 1'b0;
        step;
        bus.br_valid = 1'b0;
        step;
        check("pre_rst_valid", bus.redirect_valid, 1'b1);
        reset = 1'b1;
        step;
        check("mid_rst_valid", bus.redirect_valid, 1'b0);
        check("mid_rst_flags", bus.flags_q, 4'd0);
        check("mid_rst_cnt", bus.taken_cnt, 16'd0);
        check("mid_rst_pc", bus.redirect_pc, 32'd0);
        check("mid_rst_ready", bus.br_ready, 1'b0);
        step;
        check("mid_rst_ready2", bus.br_ready, 1'b0);
        reset = 1'b0;
        bus.redirect_ready = 1'b1;
        exp_cnt = 16'd0;
        #1;
        check("after_rst_ready", bus.br_ready, 1'b1);

        // Counter wrap on the narrow twin: 7 -> 0
        for (int i = 0; i < 7; i++) begin
            do_branch(4'd14, 32'h400, 32'd2, 1'b0, 4'd0, 1'b1, 32'h408);
        end
        check("small_cnt_full", bus_s.taken_cnt, 3'd7);
        do_branch(4'd14, 32'h400, 32'd2, 1'b0, 4'd0, 1'b1, 32'h408);
        check("small_cnt_wrap", bus_s.taken_cnt, 3'd0);
        check("main_cnt_8", bus.taken_cnt, 16'd8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
